// File: rtl/hdmi_video_pkg.sv
// Shared raster defaults, pixel widths, alignment states and output word packing
// for the HDMI video output stage.
package hdmi_video_pkg;

  localparam int H_ACTIVE_DEF = 64;
  localparam int H_FP_DEF     = 8;
  localparam int H_SYNC_DEF   = 8;
  localparam int H_BP_DEF     = 8;
  localparam int V_ACTIVE_DEF = 64;
  localparam int V_FP_DEF     = 2;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 2;

  localparam int PIX_W  = 24;
  localparam int WORD_W = 32;

  typedef enum logic {
    ALIGNED = 1'b0,
    SEEK    = 1'b1
  } align_state_t;

  function automatic logic [WORD_W-1:0] pack_pixel(input logic [PIX_W-1:0] pix);
    return {8'h00, pix};
  endfunction

endpackage

// File: rtl/hdmi_raster_counter.sv
// Horizontal/vertical raster position counters with active, sync and origin decode.
// Reset parks the raster on the first vsync line so a full vsync precedes frame one.
module hdmi_raster_counter
  import hdmi_video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic hdmi_clk,
  input  logic rst,
  output logic active,
  output logic hs,
  output logic vs,
  output logic origin,
  output logic last_active
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;

  always_ff @(posedge hdmi_clk) begin
    if (rst) begin
      hc <= '0;
      vc <= VS_FIRST;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  always_comb begin
    active      = (hc < H_ACT) && (vc < V_ACT);
    hs          = (hc >= HS_FIRST) && (hc <= HS_LAST);
    vs          = (vc >= VS_FIRST) && (vc <= VS_LAST);
    origin      = (hc == '0) && (vc == '0);
    last_active = (hc == H_ACT_LAST) && (vc == V_ACT_LAST);
  end

endmodule

// File: rtl/hdmi_video_timing_gen.sv
// Video output stage: raster timing, stream-to-raster alignment and registered HDMI outputs.
//   state   | meaning
//   ALIGNED | stream locked to raster; pixels consumed on active slots
//   SEEK    | stream misaligned; drop non-sof pixels, hold sof until raster origin
module hdmi_video_timing_gen
  import hdmi_video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic              hdmi_clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic              hdmi_vs,
  output logic              hdmi_hs,
  output logic              hdmi_de,
  output logic [WORD_W-1:0] hdmi_data,
  input  logic              err_clr,
  output logic              underflow,
  output logic              sof_err,
  output logic [7:0]        frame_cnt
);

  align_state_t state, state_nxt;
  logic active, hs, vs, origin, last_active;
  logic take_pix, uf_ev, sof_ev;

  hdmi_raster_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_raster (
    .hdmi_clk    (hdmi_clk),
    .rst         (rst),
    .active      (active),
    .hs          (hs),
    .vs          (vs),
    .origin      (origin),
    .last_active (last_active)
  );

  always_comb begin
    state_nxt = state;
    pix_ready = active;
    take_pix  = 1'b0;
    uf_ev     = 1'b0;
    sof_ev    = 1'b0;
    case (state)
      ALIGNED: begin
        take_pix = active && pix_valid;
        uf_ev    = active && !pix_valid;
        sof_ev   = take_pix && (pix_sof != origin);
        if (take_pix && pix_sof && !origin) state_nxt = SEEK;
      end
      SEEK: begin
        // Drain everything except a waiting sof, which is only released at the origin.
        pix_ready = !(pix_valid && pix_sof && !origin);
        if (pix_valid && pix_sof && origin) begin
          take_pix  = 1'b1;
          state_nxt = ALIGNED;
        end
      end
    endcase
  end

  always_ff @(posedge hdmi_clk) begin
    if (rst) begin
      state     <= ALIGNED;
      hdmi_de   <= 1'b0;
      hdmi_hs   <= 1'b0;
      hdmi_vs   <= 1'b0;
      hdmi_data <= '0;
      underflow <= 1'b0;
      sof_err   <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      hdmi_de   <= active;
      hdmi_hs   <= hs;
      hdmi_vs   <= vs;
      hdmi_data <= take_pix ? pack_pixel(pix_data) : '0;
      underflow <= uf_ev || (underflow && !err_clr);
      sof_err   <= sof_ev || (sof_err && !err_clr);
      if (last_active) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Self-checking bench for hdmi_video_timing_gen on a small 4x3 raster: scenario table,
// directed corner sequences and randomized stream checked against a position-arithmetic model.
module tb_hdmi_video_timing_gen;

  localparam int HA = 4, HF = 2, HS = 2, HB = 2;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int P0 = (VA + VF) * HT;
  localparam int NPIX = HA * VA;

  logic        hdmi_clk = 1'b0;
  logic        rst = 1'b1, pix_valid = 1'b0, pix_sof = 1'b0, err_clr = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_ready, hdmi_vs, hdmi_hs, hdmi_de, underflow, sof_err;
  logic [31:0] hdmi_data;
  logic [7:0]  frame_cnt;

  int errors = 0, checks = 0;

  hdmi_video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .hdmi_clk (hdmi_clk), .rst (rst),
    .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data), .pix_ready(pix_ready),
    .hdmi_vs  (hdmi_vs), .hdmi_hs(hdmi_hs), .hdmi_de(hdmi_de), .hdmi_data(hdmi_data),
    .err_clr  (err_clr), .underflow(underflow), .sof_err(sof_err), .frame_cnt(frame_cnt)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  // reference model state: cycle index since reset, seek flag, expected registered outputs
  bit          m_known = 0, m_seek = 0;
  int          m_t = 0;
  bit          e_de, e_hs, e_vs, e_uf, e_se;
  logic [31:0] e_data;
  logic [7:0]  e_fc;
  bit          s_de, s_vs, s_ready;

  int          src_k = 0;
  logic [7:0]  src_f = 0, src_b = 8'h5a;

  typedef struct {
    int frames;
    int gap_slot;
    int sof_slot;
    bit clr;
    bit uf;
    bit se;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pos_of(int t);
    return (P0 + t) % FT;
  endfunction

  function automatic int slot_t(int s);
    return (FT - P0) + (s / HA) * HT + (s % HA);
  endfunction

  task automatic cycle(bit r, bit v, bit s, logic [23:0] d, bit c);
    int p, h, l;
    bit act, org, rdy, uf_ev, se_ev;
    rst = r; pix_valid = v; pix_sof = s; pix_data = d; err_clr = c;
    @(negedge hdmi_clk);
    p = pos_of(m_t); h = p % HT; l = p / HT;
    act = (h < HA) && (l < VA);
    org = (p == 0);
    rdy = m_seek ? !(v && s && !org) : act;
    s_de = hdmi_de; s_vs = hdmi_vs; s_ready = pix_ready;
    if (m_known) begin
      chk("de", hdmi_de, e_de);
      chk("hs", hdmi_hs, e_hs);
      chk("vs", hdmi_vs, e_vs);
      chk("data", hdmi_data, e_data);
      chk("underflow", underflow, e_uf);
      chk("sof_err", sof_err, e_se);
      chk("frame_cnt", frame_cnt, e_fc);
      chk("ready", pix_ready, rdy);
    end
    if (r) begin
      m_known = 1; m_t = 0; m_seek = 0;
      e_de = 0; e_hs = 0; e_vs = 0; e_data = 0; e_uf = 0; e_se = 0; e_fc = 0;
    end else if (m_known) begin
      e_de = act;
      e_hs = (h >= HA + HF) && (h < HA + HF + HS);
      e_vs = (l >= VA + VF) && (l < VA + VF + VS);
      if (!m_seek) begin
        e_data = (act && v) ? {8'h00, d} : 32'h0;
        uf_ev  = act && !v;
        se_ev  = act && v && (s != org);
        m_seek = act && v && s && !org;
      end else begin
        e_data = (org && v && s) ? {8'h00, d} : 32'h0;
        uf_ev  = 0;
        se_ev  = 0;
        m_seek = !(org && v && s);
      end
      e_uf = uf_ev || (e_uf && !c);
      e_se = se_ev || (e_se && !c);
      if (p == (VA - 1) * HT + HA - 1) e_fc = e_fc + 8'd1;
      m_t++;
    end
    @(posedge hdmi_clk);
    #1;
  endtask

  // raster-locked source: a gap or a slot drained by the DUT both advance to the next pixel
  task automatic src_cycle(bit gap, bit restart, bit clr);
    if (restart) src_k = 0;
    cycle(1'b0, !gap, !gap && (src_k == 0), {src_f, 8'(src_k), src_b}, clr);
    if (s_ready) begin
      src_b = 8'($urandom);
      src_k = (src_k + 1) % NPIX;
      if (src_k == 0) src_f++;
    end
  endtask

  task automatic do_reset(int n);
    src_k = 0; src_f = 0;
    repeat (n) cycle(1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic first_frame(string tag);
    int t_rdy, t_de, n_vs;
    t_rdy = -1; t_de = -1; n_vs = 0;
    for (int t = 0; t < 30; t++) begin
      src_cycle(1'b0, 1'b0, 1'b0);
      if (s_ready && t_rdy < 0) t_rdy = t;
      if (s_de && t_de < 0) t_de = t;
      if (t_de < 0 && s_vs) n_vs++;
    end
    chk({tag, "_first_ready"}, t_rdy, FT - P0);
    chk({tag, "_first_de"}, t_de, FT - P0 + 1);
    chk({tag, "_vs_clocks"}, n_vs, VS * HT);
  endtask

  initial begin
    vecs[0] = '{3, -1, -1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2,  5, -1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{3, -1,  2, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{2,  0, -1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{2, 11, -1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{2, -1, 11, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 6; i++) begin
      do_reset(2);
      for (int t = 0; t < vecs[i].frames * FT; t++)
        src_cycle(vecs[i].gap_slot >= 0 && t == slot_t(vecs[i].gap_slot),
                  vecs[i].sof_slot >= 0 && t == slot_t(vecs[i].sof_slot), 1'b0);
      chk($sformatf("row%0d_underflow", i), underflow, vecs[i].uf);
      chk($sformatf("row%0d_sof_err", i), sof_err, vecs[i].se);
      chk($sformatf("row%0d_frame_cnt", i), frame_cnt, vecs[i].frames);
      if (vecs[i].clr) begin
        cycle(1'b0, 1'b0, 1'b0, 24'h0, 1'b1);
        chk($sformatf("row%0d_clr_underflow", i), underflow, 0);
        chk($sformatf("row%0d_clr_sof_err", i), sof_err, 0);
      end
    end

    do_reset(3);
    chk("rst_de", hdmi_de, 0);
    chk("rst_vs", hdmi_vs, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    first_frame("por");

    // err_clr coinciding with a fresh underflow event keeps the flag set
    do_reset(2);
    for (int t = 0; t < slot_t(3) + 2; t++) begin
      if (t == slot_t(1)) src_cycle(1'b1, 1'b0, 1'b0);
      else if (t == slot_t(2)) begin
        cycle(1'b0, 1'b0, 1'b0, 24'h0, 1'b1);
        chk("uf_clr_same_cycle", underflow, 1);
      end else if (t == slot_t(3) + 1) begin
        cycle(1'b0, 1'b0, 1'b0, 24'h0, 1'b1);
        chk("uf_clr_blank", underflow, 0);
      end else src_cycle(1'b0, 1'b0, 1'b0);
    end

    // one-cycle reset in the middle of an active line
    do_reset(2);
    for (int t = 0; t < FT + slot_t(5); t++) src_cycle(1'b0, 1'b0, 1'b0);
    chk("pre_rst_frame_cnt", frame_cnt, 1);
    cycle(1'b1, 1'b1, 1'b0, 24'hffffff, 1'b0);
    chk("mid_rst_de", hdmi_de, 0);
    chk("mid_rst_hs", hdmi_hs, 0);
    chk("mid_rst_data", hdmi_data, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    src_k = 0; src_f = 0;
    first_frame("mid_rst");

    do_reset(2);
    for (int t = 0; t < 255 * FT; t++) src_cycle(1'b0, 1'b0, 1'b0);
    chk("frame_cnt_255", frame_cnt, 255);
    for (int t = 0; t < FT; t++) src_cycle(1'b0, 1'b0, 1'b0);
    chk("frame_cnt_wrap", frame_cnt, 0);

    do_reset(2);
    for (int i = 0; i < 3000; i++)
      src_cycle($urandom_range(0, 9) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 39) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
